if_fetch_buffer: RTL and testbench

IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

---
 rtl/cpu_defines.sv | 27 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/if_fetch_buffer.sv | 137 +++++++++++++
 tb/tb_if_fetch_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared fetch-path widths, constants and state encoding
//
// Contents:
//   InstAddrBus / InstBus : instruction address and instruction word widths
//   ZeroWord              : all-zero instruction-bus word
//   fetch_state_t         : fetch FSM encoding (IDLE, WAIT, DROP)
//   fetch_entry_t         : one buffered fetch {pc, inst, exc}, 65 bits

package cpu_defines;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, data will be buffered
    DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
    logic                   exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched instruction entries
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the buffer next cycle (overrides push and pop)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, combinational
//   count      : occupancy, $clog2(DEPTH)+1 bits

import cpu_defines::*;

module fetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & (count != FULL);
  assign do_pop  = pop & (count != '0);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - instruction fetch request engine with decode-side buffer
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : discard buffered and in-flight fetches
//   ce_i, pc_i          : PC-stage fetch address and its valid
//   pc_invalid_i        : pc_i is misaligned; buffered as an exception entry
//   stall_req           : PC not accepted this cycle
//   imem_req, imem_addr : single-outstanding instruction memory request
//   imem_ack, imem_rdata: request completion and instruction word
//   id_valid, id_ready  : decode handshake on the buffer head
//   id_pc, id_inst, id_exc : head entry fields

import cpu_defines::*;

module if_fetch_buffer #(
  parameter int                 DEPTH    = 4,
  parameter logic [InstBus-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   pc_invalid_i,
  output logic                   stall_req,
  output logic                   imem_req,
  output logic [InstAddrBus-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [InstBus-1:0]     imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_exc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_X  = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] DEPTH_M1 = (CNT_W+1)'(DEPTH - 1);

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           occ;
  logic                     exc_pend;
  logic [InstAddrBus-1:0]   exc_pc;
  logic                     accept;
  logic                     fetch;
  logic                     push;
  logic                     pop;
  fetch_entry_t             push_data;
  fetch_entry_t             head;

  // An exception entry accepted last cycle is written this cycle; counting
  // it as occupied keeps a back-to-back accept from overrunning the buffer.
  assign occ = {1'b0, count} + {{CNT_W{1'b0}}, exc_pend};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (fetch) state_next = WAIT;
      WAIT: begin
        if (flush)         state_next = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_next = fetch ? WAIT : IDLE;
      end
      DROP: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    accept = 1'b0;
    if (ce_i && !flush) begin
      case (state)
        IDLE:    accept = (occ < DEPTH_X);
        WAIT:    accept = imem_ack && (occ < DEPTH_M1);
        default: accept = 1'b0;
      endcase
    end
    fetch     = accept & ~pc_invalid_i;
    stall_req = ~accept;
    push      = 1'b0;
    push_data = '{pc: imem_addr, inst: imem_rdata, exc: 1'b0};
    if (!flush) begin
      if (exc_pend) begin
        push      = 1'b1;
        push_data = '{pc: exc_pc, inst: NOP_INST, exc: 1'b1};
      end else if (state == WAIT && imem_ack) begin
        push = 1'b1;
      end
    end
    pop = id_valid & id_ready;
  end

  // Request and pending-exception registers. imem_addr only loads on a
  // fetch, which happens only when no request is outstanding or on the ack
  // cycle, so address and request stay stable while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= ZeroWord;
      exc_pend  <= 1'b0;
      exc_pc    <= ZeroWord;
    end else begin
      imem_req <= (state_next != IDLE);
      if (fetch) imem_addr <= pc_i;
      exc_pend <= accept & pc_invalid_i;
      if (accept && pc_invalid_i) exc_pc <= pc_i;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != '0);
  assign id_pc    = head.pc;
  assign id_inst  = head.inst;
  assign id_exc   = head.exc;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - self-checking bench for if_fetch_buffer

module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        pc_invalid_i;
  logic        stall_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_exc;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(4), .NOP_INST(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .pc_invalid_i (pc_invalid_i),
    .stall_req    (stall_req),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_exc       (id_exc)
  );

  typedef struct {
    logic        flush;
    logic        ce;
    logic [31:0] pc;
    logic        inv;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_exc;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0; ce_i = 1'b0; pc_i = 32'h0; pc_invalid_i = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int got;
    logic [31:0] exp_pc;

    // flush ce  pc  inv ack rdata rdy | stall req addr valid pc inst exc
    vt[0]  = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h0,1'b0,32'h0,32'h0,       1'b0};
    vt[1]  = '{1'b0,1'b1,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b0,1'b0,32'h0,1'b0,32'h0,32'h0,       1'b0};
    vt[2]  = '{1'b0,1'b1,32'h4, 1'b0,1'b1,32'h11111111,1'b1, 1'b0,1'b1,32'h0,1'b0,32'h0,32'h0,       1'b0};
    vt[3]  = '{1'b0,1'b1,32'h8, 1'b0,1'b1,32'h22222222,1'b1, 1'b0,1'b1,32'h4,1'b1,32'h0,32'h11111111,1'b0};
    vt[4]  = '{1'b0,1'b0,32'h0, 1'b0,1'b1,32'h33333333,1'b1, 1'b1,1'b1,32'h8,1'b1,32'h4,32'h22222222,1'b0};
    vt[5]  = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h8,1'b1,32'h8,32'h33333333,1'b0};
    vt[6]  = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h8,1'b0,32'h0,32'h0,       1'b0};
    vt[7]  = '{1'b0,1'b1,32'h6, 1'b1,1'b0,32'h0,       1'b0, 1'b0,1'b0,32'h8,1'b0,32'h0,32'h0,       1'b0};
    vt[8]  = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b0, 1'b1,1'b0,32'h8,1'b0,32'h0,32'h0,       1'b0};
    vt[9]  = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h8,1'b1,32'h6,32'h0,       1'b1};
    vt[10] = '{1'b1,1'b1,32'h40,1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h8,1'b0,32'h0,32'h0,       1'b0};
    vt[11] = '{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h8,1'b0,32'h0,32'h0,       1'b0};

    // Zero-wait fetch of 0x0/0x4/0x8, exception entry at 0x6, flush in IDLE.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      flush = vt[i].flush; ce_i = vt[i].ce; pc_i = vt[i].pc; pc_invalid_i = vt[i].inv;
      imem_ack = vt[i].ack; imem_rdata = vt[i].rdata; id_ready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_req", i),   32'(imem_req),  32'(vt[i].e_req));
      chk($sformatf("v%0d_addr", i),  imem_addr,      vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(id_valid),  32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_id_pc", i),   id_pc,        vt[i].e_pc);
        chk($sformatf("v%0d_id_inst", i), id_inst,      vt[i].e_inst);
        chk($sformatf("v%0d_id_exc", i),  32'(id_exc),  32'(vt[i].e_exc));
      end
      step();
    end

    // Decode stalled: five sequential PCs, only four fit.
    do_reset();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      ce_i = (idx < 5); pc_i = 32'h100 + 32'(4 * idx); pc_invalid_i = 1'b0;
      imem_ack = imem_req; imem_rdata = ~imem_addr; id_ready = 1'b0;
      @(negedge clk);
      if (ce_i && !stall_req) idx++;
      step();
    end
    chk("full_accepted", 32'(idx), 32'd4);
    ce_i = 1'b1; pc_i = 32'h110; imem_ack = 1'b0;
    @(negedge clk);
    chk("full_stall", 32'(stall_req), 32'd1);
    chk("full_valid", 32'(id_valid), 32'd1);
    chk("full_head_pc", id_pc, 32'h100);
    chk("full_head_inst", id_inst, ~32'h100);
    chk("full_req", 32'(imem_req), 32'd0);
    step();
    id_ready = 1'b1;
    @(negedge clk);
    chk("pop_cycle_stall", 32'(stall_req), 32'd1);
    step();
    id_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_accept", 32'(stall_req), 32'd0);
    step();
    ce_i = 1'b0;
    got = 0;
    exp_pc = 32'h104;
    for (int c = 0; c < 20; c++) begin
      imem_ack = imem_req; imem_rdata = ~imem_addr; id_ready = 1'b1;
      @(negedge clk);
      if (id_valid) begin
        chk($sformatf("drain%0d_pc", got), id_pc, exp_pc);
        chk($sformatf("drain%0d_inst", got), id_inst, ~exp_pc);
        exp_pc = exp_pc + 32'h4;
        got++;
      end
      step();
    end
    chk("drain_count", 32'(got), 32'd4);

    // Flush while waiting: response is dropped, PC stage held until the ack.
    do_reset();
    ce_i = 1'b1; pc_i = 32'h100;
    @(negedge clk);
    chk("drop_accept", 32'(stall_req), 32'd0);
    step();
    ce_i = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("drop_flush_req", 32'(imem_req), 32'd1);
    step();
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      ce_i = 1'b1; pc_i = 32'h200;
      @(negedge clk);
      chk($sformatf("drop%0d_stall", c), 32'(stall_req), 32'd1);
      chk($sformatf("drop%0d_req", c), 32'(imem_req), 32'd1);
      chk($sformatf("drop%0d_addr", c), imem_addr, 32'h100);
      chk($sformatf("drop%0d_valid", c), 32'(id_valid), 32'd0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("drop_ack_stall", 32'(stall_req), 32'd1);
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("drop_next_accept", 32'(stall_req), 32'd0);
    chk("drop_next_req", 32'(imem_req), 32'd0);
    chk("drop_next_valid", 32'(id_valid), 32'd0);
    step();
    ce_i = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("drop_new_req", 32'(imem_req), 32'd1);
    chk("drop_new_addr", imem_addr, 32'h200);
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("drop_new_valid", 32'(id_valid), 32'd1);
    chk("drop_new_pc", id_pc, 32'h200);
    chk("drop_new_inst", id_inst, 32'hCAFEF00D);
    step();

    // Three buffered entries, flush together with a pop.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ce_i = 1'b1; pc_invalid_i = 1'b1; pc_i = 32'h10 + 32'(4 * k);
      @(negedge clk);
      chk($sformatf("fill%0d_accept", k), 32'(stall_req), 32'd0);
      step();
    end
    ce_i = 1'b0; pc_invalid_i = 1'b0;
    @(negedge clk);
    chk("fill_valid", 32'(id_valid), 32'd1);
    chk("fill_head_pc", id_pc, 32'h10);
    chk("fill_head_exc", 32'(id_exc), 32'd1);
    step();
    flush = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk("flush_pre_valid", 32'(id_valid), 32'd1);
    step();
    flush = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("flush_post_valid", 32'(id_valid), 32'd0);
    step();
    ce_i = 1'b1; pc_i = 32'h500;
    @(negedge clk);
    chk("flush_hold_valid", 32'(id_valid), 32'd0);
    chk("flush_idle_accept", 32'(stall_req), 32'd0);
    step();
    ce_i = 1'b0;

    // Reset during an outstanding request; the late ack is ignored.
    do_reset();
    ce_i = 1'b1; pc_i = 32'h300;
    @(negedge clk);
    chk("rstw_accept", 32'(stall_req), 32'd0);
    step();
    ce_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstw_req_before", 32'(imem_req), 32'd1);
    step();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstw_req", 32'(imem_req), 32'd0);
    chk("rstw_addr", imem_addr, 32'h0);
    chk("rstw_valid", 32'(id_valid), 32'd0);
    step();
    imem_ack = 1'b0; ce_i = 1'b1; pc_i = 32'h400;
    @(negedge clk);
    chk("rstw_late_valid", 32'(id_valid), 32'd0);
    chk("rstw_idle_accept", 32'(stall_req), 32'd0);
    step();
    ce_i = 1'b0;
    @(negedge clk);
    chk("rstw_new_req", 32'(imem_req), 32'd1);
    chk("rstw_new_addr", imem_addr, 32'h400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
